// File: rtl/serial_add_sequencer.sv
// Nibble-serial adder sequencer: drives an external 4-bit adder one slice per
// cycle, rippling the carry through a register and assembling a W-bit result.
module serial_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_word,
  input  logic [4*NIBBLES-1:0] b_word,
  input  logic                 cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_carry,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 busy,
  output logic                 done
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     result_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             last_s;

  assign last_s = (idx_r == LAST_IDX);

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; busy/done registered from the next state so they are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand capture and per-slice accumulation; idx saturates at the top slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      idx_r    <= '0;
      carry_r  <= 1'b0;
      cout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a_word;
            b_r     <= b_word;
            carry_r <= cin;
            idx_r   <= '0;
          end
        end
        RUN: begin
          result_r[{idx_r, 2'b00} +: 4] <= add_sum;
          carry_r                       <= add_carry;
          if (last_s) begin
            cout_r <= add_carry;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Adder operand mux: only the active slice is presented, zeros otherwise
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_r == RUN) begin
      add_a   = a_r[{idx_r, 2'b00} +: 4];
      add_b   = b_r[{idx_r, 2'b00} +: 4];
      add_cin = carry_r;
    end else begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
    end
  end

  assign result = result_r;
  assign cout   = cout_r;
  assign busy   = busy_r;
  assign done   = done_r;

  serial_add_sequencer_chk u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .busy    (busy_r),
    .done    (done_r),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin)
  );

endmodule

// Protocol checker for the sequencer outputs.
module serial_add_sequencer_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       busy,
  input logic       done,
  input logic [3:0] add_a,
  input logic [3:0] add_b,
  input logic       add_cin
);

  a_done_busy: assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

  a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    !busy |-> (add_a == 4'h0 && add_b == 4'h0 && !add_cin));

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer with a behavioural 4-bit adder on the add_* ports.
module tb_serial_add_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start = 1'b0;
  logic [W-1:0] a_word = '0;
  logic [W-1:0] b_word = '0;
  logic         cin = 1'b0;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_carry;
  logic [W-1:0] result;
  logic         cout, busy, done;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W:0]   sum;
    int           acc;
  } op_t;

  op_t        sb_q[$];
  int         passed = 0;
  int         total  = 0;
  int         cyc    = 0;
  logic [W:0] last_sum = '0;

  always #5 clk = ~clk;

  assign {add_carry, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  serial_add_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_word    (a_word),
    .b_word    (b_word),
    .cin       (cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_carry (add_carry),
    .result    (result),
    .cout      (cout),
    .busy      (busy),
    .done      (done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares every cycle against the op at the head of the scoreboard
  always @(negedge clk) begin
    op_t        o;
    int         idx;
    int         sh;
    logic [W:0] mask, lo_sum;
    if (rst_n === 1'b1) begin
      if (busy) begin
        if (sb_q.size() == 0) begin
          check("busy_without_op", {16'h0, busy}, '0);
        end else begin
          o   = sb_q[0];
          idx = cyc - o.acc;
          if (!done) begin
            if (idx >= NIBBLES) begin
              check("done_late", 17'(idx), 17'(NIBBLES - 1));
              void'(sb_q.pop_front());
            end else begin
              sh     = 4 * idx;
              mask   = ((W+1)'(1) << sh) - (W+1)'(1);
              lo_sum = ({1'b0, o.a} & mask) + ({1'b0, o.b} & mask) + (W+1)'(o.ci);
              check("add_a",   17'(add_a),   17'((o.a >> sh) & 16'hF));
              check("add_b",   17'(add_b),   17'((o.b >> sh) & 16'hF));
              check("add_cin", 17'(add_cin), 17'((lo_sum >> sh) & 17'h1));
            end
          end else begin
            check("latency", 17'(cyc), 17'(o.acc + NIBBLES));
            check("result",  {cout, result}, o.sum);
            last_sum = o.sum;
            void'(sb_q.pop_front());
          end
        end
      end else begin
        check("idle_done",  17'(done), 17'h0);
        check("idle_adder", 17'({add_a, add_b, add_cin}), 17'h0);
        check("hold",       {cout, result}, last_sum);
      end
    end
  end

  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int  n;
    op_t o;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 17'(busy), 17'h0);
    a_word = a;
    b_word = b;
    cin    = ci;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    o.a    = a;
    o.b    = b;
    o.ci   = ci;
    o.sum  = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    o.acc  = cyc;
    sb_q.push_back(o);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 17'(sb_q.size()), 17'h0);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_result", {cout, result}, '0);
    check("rst_flags",  17'({busy, done}), 17'h0);
    check("rst_adder",  17'({add_a, add_b, add_cin}), 17'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    do_add(16'h1234, 16'h4321, 1'b0);
    do_add(16'hFFFF, 16'h0001, 1'b0);
    do_add(16'hFFFF, 16'hFFFF, 1'b1);

    // start during RUN with other operands must be ignored
    do_add(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
    a_word = 16'h0001;
    b_word = 16'h0001;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    do_add(16'h0001, 16'h0001, 1'b0);
    drain();

    // reset in the second RUN cycle aborts with no done pulse
    do_add(16'h1234, 16'h4321, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_result", {cout, result}, '0);
    check("abort_flags",  17'({busy, done}), 17'h0);
    check("abort_adder",  17'({add_a, add_b, add_cin}), 17'h0);
    sb_q.delete();
    last_sum = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_add(16'h0F0F, 16'h0101, 1'b0);

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_add(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (%0d/%0d)", passed, total);
    $fatal(1);
  end

endmodule
